sipo_deframer: RTL and testbench

- Downstream partner of the 10-bit PISO shifter: receives its serial stream and reassembles parallel words.
- Frame start is marked by START; bits are qualified by SI_VALID.
- Completed words are held in a one-entry output buffer and delivered with a valid/ready handshake.
- Overrun and mis-framing are reported by sticky error flags.

---
 rtl/sipo_pkg.sv | 14 +
 rtl/sipo_out_buf.sv | 43 ++++
 rtl/sipo_deframer.sv | 112 +++++++++++
 tb/tb_sipo_deframer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deframer
// and the stream stages built around it.
`timescale 1ns/1ps
package sipo_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  localparam int DEF_WIDTH = 10;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register. A load is taken whenever the slot
// is empty or being popped in the same cycle; otherwise o_overrun pulses.
`timescale 1ns/1ps
module sipo_out_buf
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             w_pop;
  logic             w_accept;

  assign w_pop     = r_valid & i_ready;
  assign w_accept  = i_load & (~r_valid | i_ready);
  assign o_overrun = i_load & r_valid & ~i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) r_data <= i_data;
      // load-over-pop keeps valid high with no bubble
      if (w_accept)   r_valid <= 1'b1;
      else if (w_pop) r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/sipo_deframer.sv
// Reassembles START-delimited serial frames into WIDTH-bit words and hands
// them off through a one-entry buffer; overrun and mis-framing are sticky.
`timescale 1ns/1ps
module sipo_deframer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             SI,
  input  logic             SI_VALID,
  input  logic             START,
  output logic [WIDTH-1:0] PO,
  output logic             PO_VALID,
  input  logic             PO_READY,
  output logic             BUSY,
  output logic             OVERRUN,
  output logic             SYNC_ERR,
  input  logic             CLR_ERR
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_e           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_sr, w_sr_shift;
  logic             w_shift_en, w_word_done, w_sync_set, w_ovr_set;
  logic             r_overrun, r_sync_err;

  generate
    if (MSB_FIRST) begin : g_msb
      assign w_sr_shift = {r_sr[WIDTH-2:0], SI};
    end else begin : g_lsb
      assign w_sr_shift = {SI, r_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (SI_VALID && START) w_state_nxt = SHIFT;
      SHIFT:   if (SI_VALID && !START && r_cnt == LAST) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // START always restarts the count, even on the would-be final bit
  always_comb begin
    w_shift_en  = 1'b0;
    w_word_done = 1'b0;
    w_sync_set  = 1'b0;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (SI_VALID && START) begin
        w_shift_en = 1'b1;
        w_cnt_nxt  = ONE;
      end
      SHIFT: if (SI_VALID) begin
        w_shift_en = 1'b1;
        if (START) begin
          w_sync_set = 1'b1;
          w_cnt_nxt  = ONE;
        end else if (r_cnt == LAST) begin
          w_word_done = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ONE;
        end
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_cnt      <= '0;
      r_sr       <= '0;
      r_overrun  <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_shift_en) r_sr <= w_sr_shift;
      r_overrun  <= w_ovr_set  | (r_overrun  & ~CLR_ERR);
      r_sync_err <= w_sync_set | (r_sync_err & ~CLR_ERR);
    end
  end

  sipo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .i_clk     (CLK),
    .i_rst_n   (RESETN),
    .i_load    (w_word_done),
    .i_data    (w_sr_shift),
    .i_ready   (PO_READY),
    .o_data    (PO),
    .o_valid   (PO_VALID),
    .o_overrun (w_ovr_set)
  );

  assign BUSY     = (r_state == SHIFT);
  assign OVERRUN  = r_overrun;
  assign SYNC_ERR = r_sync_err;

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed bench for sipo_deframer: words are queued as frames are sent and
// checked when the consumer pops them; timing and flags checked inline.
`timescale 1ns/1ps
module tb_sipo_deframer;

  localparam int W = 10;

  logic         CLK = 1'b0;
  logic         RESETN, SI, SI_VALID, START, PO_READY, CLR_ERR;
  logic [W-1:0] PO, PO1;
  logic         PO_VALID, BUSY, OVERRUN, SYNC_ERR;
  logic         PO_VALID1, BUSY1, OVERRUN1, SYNC_ERR1;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] w;

  always #5 CLK = ~CLK;

  sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .CLK(CLK), .RESETN(RESETN), .SI(SI), .SI_VALID(SI_VALID), .START(START),
    .PO(PO), .PO_VALID(PO_VALID), .PO_READY(PO_READY), .BUSY(BUSY),
    .OVERRUN(OVERRUN), .SYNC_ERR(SYNC_ERR), .CLR_ERR(CLR_ERR)
  );

  sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .CLK(CLK), .RESETN(RESETN), .SI(SI), .SI_VALID(SI_VALID), .START(START),
    .PO(PO1), .PO_VALID(PO_VALID1), .PO_READY(PO_READY), .BUSY(BUSY1),
    .OVERRUN(OVERRUN1), .SYNC_ERR(SYNC_ERR1), .CLR_ERR(CLR_ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic beat(input logic si, input logic st);
    SI_VALID = 1'b1; SI = si; START = st;
    @(posedge CLK); #1;
    SI_VALID = 1'b0; SI = 1'b0; START = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) beat(v[W-1-i], i == 0);
  endtask

  // every handshake that completes at the next edge must match the queue head
  always @(negedge CLK) begin
    if (RESETN && PO_VALID && PO_READY) begin
      if (q.size() == 0) begin
        n_tests++; n_fail++;
        $error("FAIL pop_empty: observed pop of %0h expected no word", PO);
      end else begin
        chk("po_word", 32'(PO), 32'(q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail);
  end

  initial begin
    RESETN = 1'b0; SI = 1'b0; SI_VALID = 1'b0; START = 1'b0;
    PO_READY = 1'b0; CLR_ERR = 1'b0;
    #1;
    chk("rst_po", 32'(PO), 0);
    chk("rst_vld", 32'(PO_VALID), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_ovr", 32'(OVERRUN), 0);
    chk("rst_sync", 32'(SYNC_ERR), 0);
    chk("rst_po_lsb", 32'(PO1), 0);
    tick(2);
    RESETN = 1'b1;
    tick(1);

    // contiguous frame, consumer always ready
    PO_READY = 1'b1;
    w = 10'h2B5; q.push_back(w);
    for (int i = 0; i < W; i++) begin
      beat(w[W-1-i], i == 0);
      if (i < W-1) begin
        chk("t1_busy", 32'(BUSY), 1);
        chk("t1_early_vld", 32'(PO_VALID), 0);
      end
    end
    chk("t1_vld", 32'(PO_VALID), 1);
    chk("t1_po", 32'(PO), 32'h2B5);
    chk("t1_busy_end", 32'(BUSY), 0);
    tick(2);
    chk("t1_vld_clr", 32'(PO_VALID), 0);

    // same word with idle gaps after beats 3 and 7
    q.push_back(w);
    for (int i = 0; i < W; i++) begin
      beat(w[W-1-i], i == 0);
      if (i == 2 || i == 6) tick(1);
      if (i == W-2) chk("t2_early_vld", 32'(PO_VALID), 0);
    end
    chk("t2_vld", 32'(PO_VALID), 1);
    chk("t2_po", 32'(PO), 32'h2B5);
    chk("t2_ovr", 32'(OVERRUN), 0);
    chk("t2_sync", 32'(SYNC_ERR), 0);
    tick(2);

    // overrun: buffer full, second word dropped
    PO_READY = 1'b0;
    q.push_back(10'h2B5);
    send(10'h2B5);
    chk("t3_no_ovr", 32'(OVERRUN), 0);
    send(10'h155);
    chk("t3_ovr", 32'(OVERRUN), 1);
    chk("t3_po_hold", 32'(PO), 32'h2B5);
    chk("t3_vld_hold", 32'(PO_VALID), 1);
    PO_READY = 1'b1;
    tick(1);
    PO_READY = 1'b0;
    chk("t3_vld_pop", 32'(PO_VALID), 0);
    chk("t3_po_keep", 32'(PO), 32'h2B5);
    CLR_ERR = 1'b1;
    tick(1);
    CLR_ERR = 1'b0;
    chk("t3_ovr_clr", 32'(OVERRUN), 0);

    // back-to-back frames; pop coincides with the second load
    q.push_back(10'h3FF);
    send(10'h3FF);
    w = 10'h001; q.push_back(w);
    for (int i = 0; i < W; i++) begin
      if (i == W-1) PO_READY = 1'b1;
      beat(w[W-1-i], i == 0);
      if (i == W-2) begin
        chk("t4_vld_pre", 32'(PO_VALID), 1);
        chk("t4_po_pre", 32'(PO), 32'h3FF);
      end
    end
    chk("t4_vld", 32'(PO_VALID), 1);
    chk("t4_po", 32'(PO), 32'h001);
    chk("t4_ovr", 32'(OVERRUN), 0);
    tick(2);

    // START reasserted on beat 5
    beat(1'b1, 1'b1);
    repeat (3) beat(1'b0, 1'b0);
    w = 10'h0F0; q.push_back(w);
    for (int i = 0; i < W; i++) begin
      beat(w[W-1-i], i == 0);
      if (i == 0) chk("t5_sync", 32'(SYNC_ERR), 1);
      if (i == W-2) chk("t5_early_vld", 32'(PO_VALID), 0);
    end
    chk("t5_vld", 32'(PO_VALID), 1);
    chk("t5_po", 32'(PO), 32'h0F0);
    tick(2);
    CLR_ERR = 1'b1;
    tick(1);
    CLR_ERR = 1'b0;
    chk("t5_sync_clr", 32'(SYNC_ERR), 0);

    // set beats clear in the same cycle, then reset mid-frame
    beat(1'b1, 1'b1);
    repeat (4) beat(1'b1, 1'b0);
    CLR_ERR = 1'b1;
    beat(1'b1, 1'b1);
    CLR_ERR = 1'b0;
    chk("t6_set_wins", 32'(SYNC_ERR), 1);
    chk("t6_busy", 32'(BUSY), 1);
    RESETN = 1'b0;
    #1;
    chk("t6_rst_po", 32'(PO), 0);
    chk("t6_rst_vld", 32'(PO_VALID), 0);
    chk("t6_rst_busy", 32'(BUSY), 0);
    chk("t6_rst_ovr", 32'(OVERRUN), 0);
    chk("t6_rst_sync", 32'(SYNC_ERR), 0);
    #1;
    RESETN = 1'b1;
    tick(1);
    q.push_back(10'h12A);
    send(10'h12A);
    chk("t6_vld", 32'(PO_VALID), 1);
    chk("t6_po", 32'(PO), 32'h12A);
    chk("t6_sync", 32'(SYNC_ERR), 0);
    tick(2);

    // LSB-first stream: LSB instance rebuilds 001, MSB instance sees 200
    w = 10'h001; q.push_back(10'h200);
    for (int i = 0; i < W; i++) beat(w[i], i == 0);
    chk("t7_lsb_vld", 32'(PO_VALID1), 1);
    chk("t7_lsb_po", 32'(PO1), 32'h001);
    chk("t7_msb_po", 32'(PO), 32'h200);
    tick(2);

    chk("q_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
